// File: rtl/mul_sequencer.sv
// mul_sequencer: sequencing controller for the iterative shift-add unsigned
// multiplier behind multu/mfhi/mflo. It decodes the issued instruction,
// launches a WIDTH-step multiply and owns HI/LO. While a multiply is in
// flight, dependent instructions (multu, mfhi, mflo) are interlocked via stall.
// Optional feature macro: MUL_ZERO_BYPASS_EN (a zero operand skips the RUN phase).
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic             is_multu;
  logic             is_mfhi;
  logic             is_mflo;
  logic             dep;
  logic             accept;
  logic             zero_skip;
  logic             last_step;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] prod;
  logic [WIDTH:0]   upper;
  logic [2*WIDTH:0] prod_next;
  logic [CNT_W-1:0] cnt;
  logic             unused_instr_bits;

  // Register fields between op and funct play no part in this decode.
  assign unused_instr_bits = ^instr[25:6];

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign is_multu = (op == 6'd0) && (funct == 6'd25);
  assign is_mfhi  = (op == 6'd0) && (funct == 6'd16);
  assign is_mflo  = (op == 6'd0) && (funct == 6'd18);
  assign dep      = instr_valid && (is_multu || is_mfhi || is_mflo);

  assign busy   = (state != IDLE);
  assign stall  = dep && busy;
  // stall is always low in IDLE, so any valid multu seen there is accepted.
  assign accept = (state == IDLE) && instr_valid && is_multu;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_skip = (rs_data == '0) || (rt_data == '0);
`else
  assign zero_skip = 1'b0;
`endif

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier LSB is set, keeping the carry, then shift the whole product right.
  always_comb begin
    upper     = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {upper, prod[WIDTH-1:0]} >> 1;
  end

  assign mf_data = is_mfhi ? hi : (is_mflo ? lo : '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = zero_skip ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO write-back and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= rs_data;
            cnt   <= '0;
            prod  <= zero_skip ? '0 : {{(WIDTH+1){1'b0}}, rt_data};
          end
        end
        RUN: begin
          prod <= prod_next;
          cnt  <= cnt + CNT_W'(1);
        end
        DONE: begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
